// File: rtl/uart_field_tx.sv
// uart_field_tx: latches NUM_FIELDS unsigned fields on start, converts each to
// DIGITS decimal digits with a sequential double-dabble, and sends them as an
// ASCII UART 8N1 frame "f0,f1,...,fN\r\n". Fields that do not fit in DIGITS
// digits are sent as all '9' and flagged on the sticky overflow output.
//
// Handshake (valid/ready): start is a one-cycle request, taken only while busy
// is low. Inside the block a byte is offered with byte_valid/byte_data and is
// consumed on the edge where eng_ready is also high; byte_data must stay stable
// while byte_valid is high and not yet consumed.
module uart_field_tx #(
    parameter int         NUM_FIELDS   = 5,
    parameter int         FIELD_W      = 10,
    parameter int         DIGITS       = 4,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SEP_CHAR     = 8'h2C
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_FIELDS*FIELD_W-1:0] fields,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    // ceil(FIELD_W*0.302+1) nibbles always hold the full conversion result
    localparam int NIB_MIN = 1 + (FIELD_W * 302 + 999) / 1000;
    localparam int NIB     = (NIB_MIN > DIGITS) ? NIB_MIN : DIGITS;
    localparam int BCD_W   = 4 * NIB;
    localparam int BAUD_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]        CONV_LAST = 5'(FIELD_W - 1);
    localparam logic [2:0]        DIG_LAST  = 3'(DIGITS - 1);
    localparam logic [3:0]        IDX_LAST  = 4'(NUM_FIELDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONVERT,
        S_SEND_DIGIT,
        S_SEND_SEP,
        S_SEND_EOL,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t state, state_n;

    logic [NUM_FIELDS*FIELD_W-1:0] fields_q;
    logic [FIELD_W-1:0]            sh;
    logic [BCD_W-1:0]              bcd;
    logic [BCD_W-1:0]              bcd_adj;
    logic [4:0]                    conv_cnt;
    logic [2:0]                    dig_cnt;
    logic [3:0]                    idx;
    logic                          eol_second;
    logic                          sat;
    logic [3:0]                    digit;
    logic                          accept;

    // byte engine
    logic                          byte_valid;
    logic [7:0]                    byte_data;
    logic                          eng_ready;
    logic                          byte_load;
    logic                          active;
    logic [3:0]                    bit_cnt;
    logic [BAUD_W-1:0]             baud_cnt;
    logic [9:0]                    frame_sr;

    assign accept    = start && (state == S_IDLE || state == S_FINISH);
    assign busy      = !(state == S_IDLE || state == S_FINISH);
    assign done      = (state == S_FINISH);
    assign tx        = frame_sr[0];
    // engine takes a new byte when idle or on the last cycle of a stop bit
    assign eng_ready = !active || (bit_cnt == 4'd9 && baud_cnt == BAUD_LAST);
    assign byte_load = byte_valid && eng_ready;

    // double-dabble adjust, saturation detect and current digit select
    always_comb begin
        bcd_adj = bcd;
        sat     = 1'b0;
        digit   = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        for (int i = DIGITS; i < NIB; i++) begin
            sat = sat | (|bcd[4*i +: 4]);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_cnt == 3'(DIGITS - 1 - i)) digit = bcd[4*i +: 4];
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // FSM next state and byte offer to the engine
    always_comb begin
        state_n    = state;
        byte_valid = 1'b0;
        byte_data  = SEP_CHAR;
        case (state)
            S_IDLE: begin
                if (accept) state_n = S_LOAD;
            end
            S_LOAD: begin
                state_n = S_CONVERT;
            end
            S_CONVERT: begin
                if (conv_cnt == CONV_LAST) state_n = S_SEND_DIGIT;
            end
            S_SEND_DIGIT: begin
                byte_valid = 1'b1;
                byte_data  = sat ? 8'h39 : (8'h30 + {4'd0, digit});
                if (eng_ready && dig_cnt == DIG_LAST) begin
                    state_n = (idx == IDX_LAST) ? S_SEND_EOL : S_SEND_SEP;
                end
            end
            S_SEND_SEP: begin
                byte_valid = 1'b1;
                byte_data  = SEP_CHAR;
                if (eng_ready) state_n = S_LOAD;
            end
            S_SEND_EOL: begin
                byte_valid = 1'b1;
                byte_data  = eol_second ? 8'h0A : 8'h0D;
                if (eng_ready && eol_second) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (eng_ready) state_n = S_FINISH;
            end
            S_FINISH: begin
                state_n = accept ? S_LOAD : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // field latch, conversion datapath, digit/field counters and overflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            fields_q   <= '0;
            sh         <= '0;
            bcd        <= '0;
            conv_cnt   <= '0;
            dig_cnt    <= '0;
            idx        <= '0;
            eol_second <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                fields_q <= fields;
                overflow <= 1'b0;
                idx      <= '0;
            end
            case (state)
                S_LOAD: begin
                    // field 0 sits in the low bits; shifting down exposes the next one
                    sh         <= fields_q[FIELD_W-1:0];
                    fields_q   <= fields_q >> FIELD_W;
                    bcd        <= '0;
                    conv_cnt   <= '0;
                    dig_cnt    <= '0;
                    eol_second <= 1'b0;
                end
                S_CONVERT: begin
                    bcd      <= (bcd_adj << 1) | BCD_W'(sh[FIELD_W-1]);
                    sh       <= sh << 1;
                    conv_cnt <= conv_cnt + 5'd1;
                end
                S_SEND_DIGIT: begin
                    if (sat) overflow <= 1'b1;
                    if (eng_ready) dig_cnt <= dig_cnt + 3'd1;
                end
                S_SEND_SEP: begin
                    if (eng_ready) idx <= idx + 4'd1;
                end
                S_SEND_EOL: begin
                    if (eng_ready) eol_second <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // UART 8N1 byte engine: start, 8 data LSB first, stop; back-to-back loads
    always_ff @(posedge clock) begin
        if (reset) begin
            active   <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            frame_sr <= '1;
        end else if (byte_load) begin
            active   <= 1'b1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            frame_sr <= {1'b1, byte_data, 1'b0};
        end else if (active) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                frame_sr <= {1'b1, frame_sr[9:1]};
                if (bit_cnt == 4'd9) begin
                    active  <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_field_tx.sv
// Bench for uart_field_tx: four configurations, one shared UART decoder that
// checks every cycle of every bit against bytes predicted from decimal
// arithmetic on the field values.
module tb_uart_field_tx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic        start_a = 0, start_b = 0, start_c = 0, start_d = 0;
    logic [49:0] fields_a = '0, fields_b = '0;
    logic [3:0]  fields_c = '0, fields_d = '0;
    logic tx_a, busy_a, done_a, ovf_a;
    logic tx_b, busy_b, done_b, ovf_b;
    logic tx_c, busy_c, done_c, ovf_c;
    logic tx_d, busy_d, done_d, ovf_d;

    uart_field_tx #(.CLKS_PER_BIT(4)) u_a (
        .clock(clk), .reset(rst), .start(start_a), .fields(fields_a),
        .tx(tx_a), .busy(busy_a), .done(done_a), .overflow(ovf_a));
    uart_field_tx #(.DIGITS(3), .CLKS_PER_BIT(4)) u_b (
        .clock(clk), .reset(rst), .start(start_b), .fields(fields_b),
        .tx(tx_b), .busy(busy_b), .done(done_b), .overflow(ovf_b));
    uart_field_tx #(.NUM_FIELDS(1), .FIELD_W(4), .DIGITS(2), .CLKS_PER_BIT(4)) u_c (
        .clock(clk), .reset(rst), .start(start_c), .fields(fields_c),
        .tx(tx_c), .busy(busy_c), .done(done_c), .overflow(ovf_c));
    uart_field_tx #(.NUM_FIELDS(1), .FIELD_W(4), .DIGITS(1), .CLKS_PER_BIT(868)) u_d (
        .clock(clk), .reset(rst), .start(start_d), .fields(fields_d),
        .tx(tx_d), .busy(busy_d), .done(done_d), .overflow(ovf_d));

    // selected instance under observation
    int   mon_sel = 0;
    int   mon_cpb = 4;
    logic tx_s, busy_s, done_s, ovf_s;
    always_comb begin
        case (mon_sel)
            0:       begin tx_s = tx_a; busy_s = busy_a; done_s = done_a; ovf_s = ovf_a; end
            1:       begin tx_s = tx_b; busy_s = busy_b; done_s = done_b; ovf_s = ovf_b; end
            2:       begin tx_s = tx_c; busy_s = busy_c; done_s = done_c; ovf_s = ovf_c; end
            default: begin tx_s = tx_d; busy_s = busy_d; done_s = done_d; ovf_s = ovf_d; end
        endcase
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] model_q[$];
    int   v[16];
    int   n_chk = 0, n_pass = 0;
    int   bytes_seen = 0, bytes_started = 0, done_cnt = 0;
    int   first_cyc = 0, done_cyc = 0, start_cyc = 0;
    int   d0 = 0, b0 = 0, bs0 = 0;
    logic first_pending = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
    endtask

    // ---------------- model ----------------
    task automatic setv(input int a, input int b, input int c, input int d, input int e);
        for (int i = 0; i < 16; i++) v[i] = 0;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
    endtask

    // expected ASCII frame from plain decimal arithmetic
    task automatic model_frame(input int nf, input int d, output logic eovf);
        int p, q;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        model_q.delete();
        eovf = 1'b0;
        for (int f = 0; f < nf; f++) begin
            if (v[f] > p - 1) begin
                eovf = 1'b1;
                for (int k = 0; k < d; k++) model_q.push_back(8'h39);
            end else begin
                q = p / 10;
                for (int k = 0; k < d; k++) begin
                    model_q.push_back(8'(32'h30 + (v[f] / q) % 10));
                    q = q / 10;
                end
            end
            if (f < nf - 1) model_q.push_back(8'h2C);
        end
        model_q.push_back(8'h0D);
        model_q.push_back(8'h0A);
    endtask

    // pin the model against a hand-written frame body (CR LF implied)
    task automatic pin(input string name, input string lit);
        logic ok;
        ok = (model_q.size() == lit.len() + 2);
        if (ok) begin
            for (int i = 0; i < lit.len(); i++) if (model_q[i] != lit[i]) ok = 1'b0;
            if (model_q[lit.len()] != 8'h0D || model_q[lit.len()+1] != 8'h0A) ok = 1'b0;
        end
        chk(name, ok, 1);
    endtask

    task automatic commit();
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        first_pending = 1'b1;
    endtask

    task automatic mark();
        d0 = done_cnt; b0 = bytes_seen; bs0 = bytes_started;
    endtask

    // ---------------- compare process: UART decoder ----------------
    initial begin : monitor
        logic [9:0] wave;
        logic [7:0] got, want;
        logic       have_exp, bad, aborted, gap_chk;
        gap_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap_chk = 1'b0;
                exp_q.delete();
            end else begin
                if (gap_chk) begin
                    gap_chk = 1'b0;
                    chk("back_to_back_start", tx_s, 0);
                end
                if (tx_s === 1'b0) begin
                    bytes_started++;
                    if (first_pending) begin
                        first_cyc     = cyc;
                        first_pending = 1'b0;
                    end
                    have_exp = (exp_q.size() > 0);
                    want     = have_exp ? exp_q.pop_front() : 8'h00;
                    wave     = {1'b1, want, 1'b0};
                    bad = 1'b0; aborted = 1'b0; got = 8'h00;
                    for (int k = 0; k < 10 && !aborted; k++) begin
                        for (int c = 0; c < mon_cpb && !aborted; c++) begin
                            if (!(k == 0 && c == 0)) begin
                                @(negedge clk);
                                if (rst) aborted = 1'b1;
                            end
                            if (!aborted) begin
                                if (tx_s !== wave[k]) bad = 1'b1;
                                if (c == mon_cpb / 2 && k >= 1 && k <= 8) got[k-1] = tx_s;
                            end
                        end
                    end
                    if (aborted) begin
                        exp_q.delete();
                    end else begin
                        bytes_seen++;
                        if (!have_exp) begin
                            n_chk++;
                            $display("FAIL unexpected_byte: got 0x%02h expected no byte (cycle %0d)", got, cyc);
                        end else begin
                            chk("byte_value", got, want);
                            chk("bit_timing", bad, 0);
                        end
                        gap_chk = (exp_q.size() > 0);
                    end
                end
            end
        end
    end

    // done pulse recorder
    initial begin : done_rec
        forever begin
            @(negedge clk);
            if (done_s === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_start(input int sel, input logic val);
        case (sel)
            0:       start_a = val;
            1:       start_b = val;
            2:       start_c = val;
            default: start_d = val;
        endcase
    endtask

    task automatic set_fields_a();
        for (int i = 0; i < 5; i++) fields_a[i*10 +: 10] = v[i][9:0];
    endtask

    task automatic pulse(input int sel);
        @(posedge clk); #1;
        set_start(sel, 1'b1);
        start_cyc = cyc;
        @(negedge clk);
        chk("busy_low_on_start", busy_s, 0);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        @(negedge clk);
        chk("busy_after_start", busy_s, 1);
        chk("overflow_cleared", ovf_s, 0);
    endtask

    task automatic wait_done(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_s === 1'b1) begin
                ok = 1'b1;
                chk("busy_low_with_done", busy_s, 0);
                break;
            end
        end
        if (!ok) fail("done_timeout");
    endtask

    task automatic wait_bytes_started(input int n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (bytes_started >= bs0 + n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("byte_start_timeout");
    endtask

    task automatic finish_frame(input int ndone, input int nbytes, input int lat,
                                input int dlat, input logic eovf);
        repeat (20) @(negedge clk);
        #1;
        chk("done_count", done_cnt - d0, ndone);
        chk("frame_bytes", bytes_seen - b0, nbytes);
        chk("expected_queue_empty", exp_q.size(), 0);
        chk("overflow_flag", ovf_s, eovf);
        chk("first_start_latency", first_cyc - start_cyc, lat);
        chk("done_latency", done_cyc - first_cyc, dlat);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic eovf;
        int   lowrun, highrun;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", tx_a, 1);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_overflow", ovf_a, 0);
        chk("reset_tx_d", tx_d, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // T1: default format
        mon_sel = 0; mon_cpb = 4;
        setv(987, 12, 0, 345, 511);
        set_fields_a();
        model_frame(5, 4, eovf);
        pin("model_pin_t1", "0987,0012,0000,0345,0511");
        commit(); mark();
        pulse(0);
        wait_done(1300);
        finish_frame(1, 26, 13, 1040, 1'b0);

        // T2: saturation, then overflow cleared by the next frame
        mon_sel = 1;
        setv(1023, 5, 5, 5, 5);
        for (int i = 0; i < 5; i++) fields_b[i*10 +: 10] = v[i][9:0];
        model_frame(5, 3, eovf);
        pin("model_pin_t2", "999,005,005,005,005");
        chk("model_overflow_t2", eovf, 1);
        commit(); mark();
        pulse(1);
        wait_done(1100);
        finish_frame(1, 21, 13, 840, 1'b1);
        setv(5, 5, 5, 5, 5);
        for (int i = 0; i < 5; i++) fields_b[i*10 +: 10] = v[i][9:0];
        model_frame(5, 3, eovf);
        commit(); mark();
        pulse(1);
        wait_done(1100);
        finish_frame(1, 21, 13, 840, 1'b0);

        // T3: start while busy ignored, start right after done accepted
        mon_sel = 0;
        setv(1, 22, 333, 1000, 1023);
        set_fields_a();
        model_frame(5, 4, eovf);
        commit(); mark();
        pulse(0);
        wait_bytes_started(3);
        @(posedge clk); #1;
        start_a = 1'b1;
        fields_a = '1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(negedge clk);
        chk("busy_kept_on_restart", busy_a, 1);
        wait_done(1300);
        setv(7, 0, 1023, 999, 64);
        set_fields_a();
        model_frame(5, 4, eovf);
        commit();
        pulse(0);
        wait_done(1300);
        finish_frame(2, 52, 13, 1040, 1'b0);

        // T4: reset during a data bit of byte 7, then a clean frame
        setv(5, 10, 15, 20, 25);
        set_fields_a();
        model_frame(5, 4, eovf);
        commit(); mark();
        pulse(0);
        wait_bytes_started(7);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx_high", tx_a, 1);
        chk("abort_busy_low", busy_a, 0);
        chk("abort_no_done", done_a, 0);
        repeat (100) @(negedge clk);
        #1;
        chk("abort_done_count", done_cnt - d0, 0);
        chk("abort_bytes", bytes_seen - b0, 6);
        setv(1023, 0, 9, 99, 999);
        set_fields_a();
        model_frame(5, 4, eovf);
        commit(); mark();
        pulse(0);
        wait_done(1300);
        finish_frame(1, 26, 13, 1040, 1'b0);

        // T5: single narrow field, no separator
        mon_sel = 2;
        setv(9, 0, 0, 0, 0);
        fields_c = 4'd9;
        model_frame(1, 2, eovf);
        pin("model_pin_t5", "09");
        commit(); mark();
        pulse(2);
        wait_done(400);
        finish_frame(1, 4, 7, 160, 1'b0);

        // T6: real baud divisor, '0' bit widths measured directly
        mon_sel = 3; mon_cpb = 868;
        setv(0, 0, 0, 0, 0);
        fields_d = 4'd0;
        model_frame(1, 1, eovf);
        commit(); mark();
        pulse(3);
        for (int i = 0; i < 50 && tx_d !== 1'b0; i++) @(negedge clk);
        lowrun = 0;
        while (tx_d === 1'b0 && lowrun < 20000) begin
            lowrun++;
            @(negedge clk);
        end
        highrun = 0;
        while (tx_d === 1'b1 && highrun < 20000) begin
            highrun++;
            @(negedge clk);
        end
        chk("t6_start_plus_low_bits", lowrun, 5 * 868);
        chk("t6_high_bits", highrun, 2 * 868);
        wait_done(30000);
        finish_frame(1, 3, 7, 26040, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
